dmem_wbuf: RTL and testbench

Data-memory block sitting directly downstream of the multi-cycle CPU data port. It accepts byte-enabled stores into a small write buffer and drains them into an internal word array through a slow, multi-cycle write port. It returns registered read data with byte-wise forwarding from pending buffer entries, so the CPU never observes stale data while a store is still draining.

---
 rtl/dmem_pkg.sv | 37 +++
 rtl/wbuf_fifo.sv | 71 +++++++
 rtl/dmem_wbuf.sv | 131 +++++++++++++
 tb/tb_dmem_wbuf.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory write buffer: drain FSM states,
// buffer entry layout and the byte-lane merge used by both commit and forwarding.
package dmem_pkg;

  // Entry index field is sized for the largest supported array (64K words).
  localparam int unsigned IDX_W = 16;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned WAIT_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } drain_state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [3:0]       be;
    logic [31:0]      data;
  } wbuf_entry_t;

  // Replace the bytes of base selected by be with the matching bytes of data.
  function automatic logic [31:0] merge_bytes(input logic [31:0] base,
                                              input logic [31:0] data,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = base;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[b*8 +: 8] = data[b*8 +: 8];
      end else begin
        res[b*8 +: 8] = base[b*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// Circular write-buffer FIFO; exposes every slot, oldest first, with valid bits
// so the read path can overlay pending stores.
module wbuf_fifo
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  wbuf_entry_t           push_entry_i,
  input  logic                  pop_i,
  output wbuf_entry_t           entries_o [DEPTH],
  output logic [DEPTH-1:0]      valid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CNT_W-1:0]      count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wbuf_entry_t      mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok_s;
  logic             push_ok_s;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == {CNT_W{1'b0}});
  assign count_o = count_q;

  // A push into a full buffer is only accepted when the head leaves this cycle.
  always_comb begin
    pop_ok_s  = pop_i && !empty_o;
    push_ok_s = push_i && (!full_o || pop_ok_s);
    head_d    = pop_ok_s  ? head_q + PW'(1) : head_q;
    tail_d    = push_ok_s ? tail_q + PW'(1) : tail_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push_ok_s) begin
        mem_q[tail_q] <= push_entry_i;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_o[i] = mem_q[head_q + PW'(i)];
      valid_o[i]   = (CNT_W'(i) < count_q);
    end
  end

endmodule

// File: rtl/dmem_wbuf.sv
// Data memory with a byte-enabled write buffer draining through a slow array
// port; reads are registered and see pending stores via a byte-wise overlay.
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned MEM_WORDS   = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_write,
  input  logic [31:0] data_in,
  input  logic        data_read,
  output logic [31:0] data_out,
  output logic        wbuf_empty,
  output logic        wbuf_full,
  output logic        drain_busy,
  output logic        overflow
);

  localparam int unsigned IW = $clog2(MEM_WORDS);

  logic [31:0]       mem_q [MEM_WORDS];
  drain_state_t      state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [31:0]       data_out_q, data_out_d;
  logic              overflow_q, overflow_d;

  logic [IDX_W-1:0]  idx_s;
  wbuf_entry_t       push_entry_s;
  logic              push_s;
  logic              commit_s;
  wbuf_entry_t       entries_s [DEPTH];
  logic [DEPTH-1:0]  valid_s;
  logic              full_s, empty_s;
  logic [CNT_W-1:0]  count_s;
  logic [31:0]       rd_word_s;
  wbuf_entry_t       head_s;

  assign idx_s        = IDX_W'(data_addr[IW+1:2]);
  assign push_s       = (data_write != 4'b0000);
  assign push_entry_s = '{idx: idx_s, be: data_write, data: data_in};
  assign head_s       = entries_s[0];

  wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push_s),
    .push_entry_i (push_entry_s),
    .pop_i        (commit_s),
    .entries_o    (entries_s),
    .valid_o      (valid_s),
    .full_o       (full_s),
    .empty_o      (empty_s),
    .count_o      (count_s)
  );

  // Drain FSM next state, commit strobe and sticky overflow.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    commit_s   = 1'b0;
    overflow_d = overflow_q | (push_s && full_s && !commit_s);
    case (state_q)
      IDLE: begin
        if (!empty_s) begin
          state_d = BUSY;
          cnt_d   = WAIT_W'(WAIT_CYCLES);
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q != {WAIT_W{1'b0}}) begin
          cnt_d = cnt_q - WAIT_W'(1);
        end else begin
          commit_s = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {WAIT_W{1'b0}};
      end
    endcase
    overflow_d = overflow_q | (push_s && full_s && !commit_s);
  end

  // Read overlay: array word, then pending entries oldest to newest.
  always_comb begin
    rd_word_s = mem_q[idx_s[IW-1:0]];
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_s[i] && (entries_s[i].idx == idx_s)) begin
        rd_word_s = merge_bytes(rd_word_s, entries_s[i].data, entries_s[i].be);
      end else begin
        rd_word_s = rd_word_s;
      end
    end
    data_out_d = data_read ? rd_word_s : data_out_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= {WAIT_W{1'b0}};
      data_out_q <= 32'h0000_0000;
      overflow_q <= 1'b0;
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      overflow_q <= overflow_d;
      if (commit_s) begin
        mem_q[head_s.idx[IW-1:0]] <= merge_bytes(mem_q[head_s.idx[IW-1:0]],
                                                 head_s.data, head_s.be);
      end
    end
  end

  assign data_out   = data_out_q;
  assign overflow   = overflow_q;
  assign wbuf_empty = empty_s;
  assign wbuf_full  = full_s;
  assign drain_busy = (state_q == BUSY);

endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed bench for dmem_wbuf with DEPTH=4, WAIT_CYCLES=2, MEM_WORDS=256.
module tb_dmem_wbuf;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_addr = 32'h0;
  logic [3:0]  data_write = 4'h0;
  logic [31:0] data_in = 32'h0;
  logic        data_read = 1'b0;
  logic [31:0] data_out;
  logic        wbuf_empty, wbuf_full, drain_busy, overflow;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_wbuf dut (
    .clk        (clk),
    .rst        (rst),
    .data_addr  (data_addr),
    .data_write (data_write),
    .data_in    (data_in),
    .data_read  (data_read),
    .data_out   (data_out),
    .wbuf_empty (wbuf_empty),
    .wbuf_full  (wbuf_full),
    .drain_busy (drain_busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    data_addr  = a;
    data_in    = d;
    data_write = be;
    tick();
    data_write = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a);
    data_addr = a;
    data_read = 1'b1;
    tick();
    data_read = 1'b0;
  endtask

  task automatic wait_empty(input string tag, input int budget);
    for (int k = 0; k < budget && !wbuf_empty; k++) tick();
    chk(tag, {31'b0, wbuf_empty}, 32'h1);
  endtask

  task automatic chk_reset_outs(input string pfx);
    chk({pfx, "_dout"},  data_out, 32'h0);
    chk({pfx, "_empty"}, {31'b0, wbuf_empty}, 32'h1);
    chk({pfx, "_full"},  {31'b0, wbuf_full}, 32'h0);
    chk({pfx, "_busy"},  {31'b0, drain_busy}, 32'h0);
    chk({pfx, "_ovf"},   {31'b0, overflow}, 32'h0);
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk_reset_outs("rst");
    rd(32'h10);
    chk("rst_rd10", data_out, 32'h0);

    // Single store: forwarded at E1, committed at E4
    store(32'h10, 32'hDEADBEEF, 4'hF);          // E0
    data_addr = 32'h10; data_read = 1'b1;
    tick();                                    // E1
    chk("ss_fwd", data_out, 32'hDEADBEEF);
    chk("ss_busy_e1", {31'b0, drain_busy}, 32'h1);
    tick(); tick();                            // E2, E3
    chk("ss_notempty_e3", {31'b0, wbuf_empty}, 32'h0);
    tick();                                    // E4 commit
    chk("ss_empty_e4", {31'b0, wbuf_empty}, 32'h1);
    chk("ss_rd_e4", data_out, 32'hDEADBEEF);
    tick();
    chk("ss_rd_arr", data_out, 32'hDEADBEEF);
    data_read = 1'b0;

    // Byte merge
    store(32'h20, 32'h11223344, 4'hF);
    store(32'h22, 32'h0000AA00, 4'h2);
    rd(32'h20);
    chk("bm_fwd", data_out, 32'h1122AA44);
    wait_empty("bm_drain", 20);
    rd(32'h20);
    chk("bm_arr", data_out, 32'h1122AA44);

    // Overflow: six back-to-back stores
    for (int i = 0; i < 6; i++) begin
      store(32'(i * 4), 32'h100 + 32'(i), 4'hF);
      if (i == 3) chk("ov_full_e3", {31'b0, wbuf_full}, 32'h1);
      if (i == 4) chk("ov_clear_e4", {31'b0, overflow}, 32'h0);
      if (i == 5) begin
        chk("ov_set_e5", {31'b0, overflow}, 32'h1);
        chk("ov_full_e5", {31'b0, wbuf_full}, 32'h1);
      end
    end
    wait_empty("ov_drain", 40);
    rd(32'h14);
    chk("ov_rd14", data_out, 32'h0);
    rd(32'h10);
    chk("ov_rd10", data_out, 32'h104);
    rd(32'h00);
    chk("ov_rd00", data_out, 32'h100);
    chk("ov_sticky", {31'b0, overflow}, 32'h1);

    // Reset mid-drain
    rd(32'h20);
    chk("rm_pre_rd", data_out, 32'h1122AA44);
    store(32'h30, 32'hA0A0A0A0, 4'hF);
    store(32'h34, 32'hB0B0B0B0, 4'hF);
    store(32'h38, 32'hC0C0C0C0, 4'hF);
    chk("rm_busy", {31'b0, drain_busy}, 32'h1);
    chk("rm_pending", {31'b0, wbuf_empty}, 32'h0);
    rst = 1'b0;
    #1;
    chk_reset_outs("rm_async");
    tick(); tick();
    rst = 1'b1;
    rd(32'h30);
    chk("rm_rd30", data_out, 32'h0);
    rd(32'h20);
    chk("rm_rd20", data_out, 32'h0);
    rd(32'h10);
    chk("rm_rd10", data_out, 32'h0);
    chk("rm_no_drain", {31'b0, drain_busy}, 32'h0);

    // Wrap-around
    store(32'h400, 32'hCAFEF00D, 4'hF);
    rd(32'h000);
    chk("wr_fwd", data_out, 32'hCAFEF00D);
    wait_empty("wr_drain", 20);
    rd(32'h000);
    chk("wr_arr", data_out, 32'hCAFEF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
